// File: rtl/channel_monitor.sv
// channel_monitor: link-quality checker at the end of the transmit->receive
// channel. Tracks the recovered counter stream, accepts +1 steps, holds and
// the DATA_W wrap, and keeps saturating error statistics plus a
// SEARCH/LOCKED/ALARM status.
module channel_monitor #(
  parameter int DATA_W       = 9,
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 4,
  parameter int RELOCK_GOOD  = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              locked,
  output logic              alarm,
  output logic [DATA_W-1:0] last_good,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt
);

  localparam int BR_W = $clog2(ALARM_THRESH + 1);
  localparam int GR_W = $clog2(RELOCK_GOOD + 1);
  localparam logic [BR_W-1:0] BAD_LIM  = BR_W'(ALARM_THRESH);
  localparam logic [GR_W-1:0] GOOD_LIM = GR_W'(RELOCK_GOOD);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    ALARM  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] last_good_q, last_good_d;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]  par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [BR_W-1:0]   bad_run_q, bad_run_d;
  logic [GR_W-1:0]   good_run_q, good_run_d;
  logic [DATA_W-1:0] expect_next;
  logic [BR_W-1:0]   bad_run_inc;
  logic [GR_W-1:0]   good_run_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign expect_next  = last_good_q + 1'b1;
  assign bad_run_inc  = bad_run_q + 1'b1;
  assign good_run_inc = good_run_q + 1'b1;

  // Next-state and statistics update for the current input word.
  always_comb begin
    state_d     = state_q;
    last_good_d = last_good_q;
    good_cnt_d  = good_cnt_q;
    par_cnt_d   = par_cnt_q;
    seq_cnt_d   = seq_cnt_q;
    bad_run_d   = bad_run_q;
    good_run_d  = good_run_q;

    // Parity errors are counted in every state, including the alarm edge.
    if (!data_valid) par_cnt_d = sat_inc(par_cnt_q);

    case (state_q)
      SEARCH: begin
        if (data_valid) begin
          last_good_d = data_in;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (!data_valid) begin
          if (bad_run_inc == BAD_LIM) begin
            state_d    = ALARM;
            bad_run_d  = '0;
            good_run_d = '0;
          end else begin
            bad_run_d = bad_run_inc;
          end
        end else begin
          bad_run_d = '0;
          if (data_in == last_good_q) begin
            // Transmitter stalled: nothing to count.
          end else if (data_in == expect_next) begin
            good_cnt_d  = sat_inc(good_cnt_q);
            last_good_d = data_in;
          end else begin
            // Out-of-sequence word: count it and resync to it.
            seq_cnt_d   = sat_inc(seq_cnt_q);
            last_good_d = data_in;
          end
        end
      end
      ALARM: begin
        if (data_valid) begin
          last_good_d = data_in;
          if (good_run_inc == GOOD_LIM) begin
            state_d    = LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            good_run_d = good_run_inc;
          end
        end else begin
          good_run_d = '0;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // State and statistics registers, cleared asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= SEARCH;
      last_good_q <= '0;
      good_cnt_q  <= '0;
      par_cnt_q   <= '0;
      seq_cnt_q   <= '0;
      bad_run_q   <= '0;
      good_run_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_good_q <= last_good_d;
      good_cnt_q  <= good_cnt_d;
      par_cnt_q   <= par_cnt_d;
      seq_cnt_q   <= seq_cnt_d;
      bad_run_q   <= bad_run_d;
      good_run_q  <= good_run_d;
    end
  end

  assign locked         = (state_q == LOCKED);
  assign alarm          = (state_q == ALARM);
  assign last_good      = last_good_q;
  assign good_cnt       = good_cnt_q;
  assign parity_err_cnt = par_cnt_q;
  assign seq_err_cnt    = seq_cnt_q;

endmodule

// File: tb/tb_channel_monitor.sv
// Directed bench for channel_monitor with hand-computed expectations.
module tb_channel_monitor;

  logic       clk = 1'b0;
  logic       clear;
  logic [8:0] data_in;
  logic       data_valid;
  logic       locked, alarm;
  logic [8:0] last_good;
  logic [7:0] good_cnt, parity_err_cnt, seq_err_cnt;

  int total = 0;
  int bad   = 0;

  channel_monitor #(
    .DATA_W(9), .CNT_W(8), .ALARM_THRESH(4), .RELOCK_GOOD(2)
  ) dut (
    .clk            (clk),
    .clear          (clear),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .locked         (locked),
    .alarm          (alarm),
    .last_good      (last_good),
    .good_cnt       (good_cnt),
    .parity_err_cnt (parity_err_cnt),
    .seq_err_cnt    (seq_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Present one word on the falling edge, then sample just after the rising edge.
  task automatic step(input logic v, input logic [8:0] d);
    @(negedge clk);
    clear      = 1'b0;
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  // Hold clear across one rising edge; the next step releases it.
  task automatic do_clear();
    @(negedge clk);
    clear      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
  endtask

  task automatic check_all(input string tag, input logic lk, input logic al,
                           input logic [8:0] lg, input logic [7:0] gc,
                           input logic [7:0] pc, input logic [7:0] sc);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".alarm"},  32'(alarm), 32'(al));
    check({tag, ".last"},   32'(last_good), 32'(lg));
    check({tag, ".good"},   32'(good_cnt), 32'(gc));
    check({tag, ".par"},    32'(parity_err_cnt), 32'(pc));
    check({tag, ".seq"},    32'(seq_err_cnt), 32'(sc));
  endtask

  initial begin
    clear      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    #12;
    check_all("rst", 1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 8'd0);

    // Clean ramp
    step(1'b1, 9'd0);
    check_all("ramp0", 1'b1, 1'b0, 9'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 1; i <= 5; i++) step(1'b1, 9'(i));
    check_all("ramp5", 1'b1, 1'b0, 9'd5, 8'd5, 8'd0, 8'd0);

    // Stall and wrap
    do_clear();
    step(1'b1, 9'd509);
    check_all("wrap_lock", 1'b1, 1'b0, 9'd509, 8'd0, 8'd0, 8'd0);
    step(1'b1, 9'd510);
    step(1'b1, 9'd510);
    step(1'b1, 9'd510);
    check_all("hold", 1'b1, 1'b0, 9'd510, 8'd1, 8'd0, 8'd0);
    step(1'b1, 9'd511);
    step(1'b1, 9'd0);
    check_all("wrap0", 1'b1, 1'b0, 9'd0, 8'd3, 8'd0, 8'd0);
    step(1'b1, 9'd1);
    check_all("wrap1", 1'b1, 1'b0, 9'd1, 8'd4, 8'd0, 8'd0);

    // Sequence jump
    do_clear();
    step(1'b1, 9'd7);
    step(1'b1, 9'd9);
    check_all("jump9", 1'b1, 1'b0, 9'd9, 8'd0, 8'd0, 8'd1);
    step(1'b1, 9'd10);
    check_all("jump10", 1'b1, 1'b0, 9'd10, 8'd1, 8'd0, 8'd1);

    // Alarm entry after four invalid words
    for (int i = 0; i < 3; i++) step(1'b0, 9'd0);
    check_all("bad3", 1'b1, 1'b0, 9'd10, 8'd1, 8'd3, 8'd1);
    step(1'b0, 9'd0);
    check_all("bad4", 1'b0, 1'b1, 9'd10, 8'd1, 8'd4, 8'd1);

    // Relock after two valid words; the relock edge is not a good advance
    step(1'b1, 9'd20);
    check_all("relock1", 1'b0, 1'b1, 9'd20, 8'd1, 8'd4, 8'd1);
    step(1'b1, 9'd21);
    check_all("relock2", 1'b1, 1'b0, 9'd21, 8'd1, 8'd4, 8'd1);
    step(1'b1, 9'd22);
    check_all("after_relock", 1'b1, 1'b0, 9'd22, 8'd2, 8'd4, 8'd1);

    // 3 invalid, 1 valid, 3 invalid: bad run restarts, no alarm
    for (int i = 0; i < 3; i++) step(1'b0, 9'd0);
    step(1'b1, 9'd23);
    for (int i = 0; i < 3; i++) step(1'b0, 9'd0);
    check_all("no_alarm", 1'b1, 1'b0, 9'd23, 8'd3, 8'd10, 8'd1);

    // Fourth consecutive invalid trips alarm; an invalid word in ALARM restarts the good run
    step(1'b0, 9'd0);
    check_all("alarm2", 1'b0, 1'b1, 9'd23, 8'd3, 8'd11, 8'd1);
    step(1'b1, 9'd30);
    step(1'b0, 9'd0);
    step(1'b1, 9'd31);
    check_all("run_reset", 1'b0, 1'b1, 9'd31, 8'd3, 8'd12, 8'd1);
    step(1'b1, 9'd32);
    check_all("relock3", 1'b1, 1'b0, 9'd32, 8'd3, 8'd12, 8'd1);
    step(1'b1, 9'd33);
    check_all("adv33", 1'b1, 1'b0, 9'd33, 8'd4, 8'd12, 8'd1);

    // Asynchronous clear between edges
    #2;
    clear = 1'b1;
    #1;
    check_all("async_clr", 1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 8'd0);
    step(1'b1, 9'd3);
    check_all("post_clr", 1'b1, 1'b0, 9'd3, 8'd0, 8'd0, 8'd0);

    // Saturation of parity error counter
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 9'd0);
      if (i == 253) check("sat_254", 32'(parity_err_cnt), 32'd254);
      if (i == 254) check("sat_255", 32'(parity_err_cnt), 32'd255);
    end
    check_all("sat_end", 1'b0, 1'b1, 9'd3, 8'd0, 8'd255, 8'd0);
    do_clear();
    #1;
    check_all("sat_clr", 1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
